// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with BCD countdown and pedestrian-shortened main green.
// Optional flashing yellow is built when YELLOW_BLINK_EN is defined.
module traffic_light_ctrl #(
  parameter int GREEN_MAIN = 10,
  parameter int GREEN_SIDE = 5,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int PED_GREEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       tick_half,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       ped_pending,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5
  } state_t;

  localparam logic [6:0] D_GREEN_MAIN = 7'(GREEN_MAIN);
  localparam logic [6:0] D_GREEN_SIDE = 7'(GREEN_SIDE);
  localparam logic [6:0] D_YELLOW     = 7'(YELLOW);
  localparam logic [6:0] D_ALL_RED    = 7'(ALL_RED);
  localparam logic [6:0] D_PED_GREEN  = 7'(PED_GREEN);

  state_t     state, state_nxt, state_succ;
  logic [6:0] cnt, cnt_nxt, cnt_dec;
  logic       ped_nxt;
  logic       t1_d;
  logic       sec_edge;
  logic       yellow_en;

  function automatic logic [6:0] phase_dur(input state_t s);
    case (s)
      MAIN_G:       phase_dur = D_GREEN_MAIN;
      MAIN_Y:       phase_dur = D_YELLOW;
      SIDE_G:       phase_dur = D_GREEN_SIDE;
      SIDE_Y:       phase_dur = D_YELLOW;
      RED1, RED2:   phase_dur = D_ALL_RED;
      default:      phase_dur = D_GREEN_MAIN;
    endcase
  endfunction

  // Reset to 1 so a tick held high across reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) t1_d <= 1'b1;
    else        t1_d <= tick_1s;
  end

  assign sec_edge = tick_1s & ~t1_d;

  always_comb begin
    state_succ = MAIN_G;
    case (state)
      MAIN_G:  state_succ = MAIN_Y;
      MAIN_Y:  state_succ = RED1;
      RED1:    state_succ = SIDE_G;
      SIDE_G:  state_succ = SIDE_Y;
      SIDE_Y:  state_succ = RED2;
      RED2:    state_succ = MAIN_G;
      default: state_succ = MAIN_G;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_dec   = cnt;
    ped_nxt   = ped_pending | ped_req;
    if (sec_edge && cnt == 7'd1) begin
      state_nxt = state_succ;
      cnt_nxt   = phase_dur(state_succ);
    end else begin
      if (sec_edge) cnt_dec = cnt - 7'd1;
      // Pending pedestrian caps the remaining main green, applied after any decrement.
      if (state == MAIN_G && ped_pending && cnt_dec > D_PED_GREEN)
        cnt_nxt = D_PED_GREEN;
      else
        cnt_nxt = cnt_dec;
    end
    if (state_nxt == SIDE_G && state != SIDE_G) ped_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MAIN_G;
      cnt         <= D_GREEN_MAIN;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ped_pending <= ped_nxt;
    end
  end

`ifdef YELLOW_BLINK_EN
  logic th_d;
  logic half_edge;
  logic blink;
  logic yellow_entry;

  assign half_edge    = tick_half & ~th_d;
  assign yellow_entry = (state_nxt != state) && (state_nxt == MAIN_Y || state_nxt == SIDE_Y);

  // Entry into a yellow phase restarts the flash with the lamp lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_d  <= 1'b1;
      blink <= 1'b1;
    end else begin
      th_d <= tick_half;
      if (yellow_entry)   blink <= 1'b1;
      else if (half_edge) blink <= ~blink;
    end
  end

  assign yellow_en = blink;
`else
  logic unused_tick_half;
  assign unused_tick_half = tick_half;
  assign yellow_en        = 1'b1;
`endif

  always_comb begin
    main_r = 1'b0;
    main_y = 1'b0;
    main_g = 1'b0;
    side_r = 1'b0;
    side_y = 1'b0;
    side_g = 1'b0;
    case (state)
      MAIN_G: begin main_g = 1'b1;      side_r = 1'b1; end
      MAIN_Y: begin main_y = yellow_en; side_r = 1'b1; end
      RED1:   begin main_r = 1'b1;      side_r = 1'b1; end
      SIDE_G: begin side_g = 1'b1;      main_r = 1'b1; end
      SIDE_Y: begin side_y = yellow_en; main_r = 1'b1; end
      RED2:   begin main_r = 1'b1;      side_r = 1'b1; end
      default: begin main_r = 1'b1;     side_r = 1'b1; end
    endcase
  end

  assign cnt_tens  = 4'(cnt / 7'd10);
  assign cnt_ones  = 4'(cnt % 7'd10);
  assign state_dbg = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default instance plus a GREEN_MAIN=25 instance.
// Expected lamp/BCD/pending words are queued by the driver and checked by a monitor.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst_n, tick_1s, tick_half, ped_req;

  logic       main_r, main_y, main_g, side_r, side_y, side_g, ped_pending;
  logic [3:0] cnt_tens, cnt_ones;
  logic [2:0] state_dbg;

  logic       b_main_r, b_main_y, b_main_g, b_side_r, b_side_y, b_side_g, b_ped_pending;
  logic [3:0] b_cnt_tens, b_cnt_ones;
  logic [2:0] b_state_dbg;

  localparam int W = 15;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] exp2_q[$];
  string        name2_q[$];
  int checks = 0;
  int errors = 0;

  // Model-side phase state for the full-cycle walk.
  int durs[6] = '{10, 3, 1, 5, 3, 1};
  int m_st, m_c;

  traffic_light_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .tick_half(tick_half), .ped_req(ped_req),
    .main_r(main_r), .main_y(main_y), .main_g(main_g),
    .side_r(side_r), .side_y(side_y), .side_g(side_g),
    .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .ped_pending(ped_pending), .state_dbg(state_dbg)
  );

  traffic_light_ctrl #(.GREEN_MAIN(25)) dut25 (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .tick_half(tick_half), .ped_req(ped_req),
    .main_r(b_main_r), .main_y(b_main_y), .main_g(b_main_g),
    .side_r(b_side_r), .side_y(b_side_y), .side_g(b_side_g),
    .cnt_tens(b_cnt_tens), .cnt_ones(b_cnt_ones), .ped_pending(b_ped_pending),
    .state_dbg(b_state_dbg)
  );

  // Clock and reset defaults
  always #5 clk = ~clk;

  logic [W-1:0] act, act2;
  assign act  = {main_r, main_y, main_g, side_r, side_y, side_g, cnt_tens, cnt_ones, ped_pending};
  assign act2 = {b_main_r, b_main_y, b_main_g, b_side_r, b_side_y, b_side_g,
                 b_cnt_tens, b_cnt_ones, b_ped_pending};

  // st: 0 MAIN_G, 1 MAIN_Y, 2 RED1, 3 SIDE_G, 4 SIDE_Y, 5 RED2
  function automatic logic [W-1:0] ex(input int st, input int c, input logic p);
    logic [5:0] l;
    case (st)
      0:       l = 6'b001_100;
      1:       l = 6'b010_100;
      3:       l = 6'b100_001;
      4:       l = 6'b100_010;
      default: l = 6'b100_100;
    endcase
    return {l, 4'(c / 10), 4'(c % 10), p};
  endfunction

  // Driver tasks
  task automatic step(input logic t1, input logic th, input logic pr);
    @(negedge clk);
    tick_1s   = t1;
    tick_half = th;
    ped_req   = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input int st, input int c, input logic p, input string name);
    exp_q.push_back(ex(st, c, p));
    name_q.push_back(name);
  endtask

  task automatic expect_w(input logic [W-1:0] w, input string name);
    exp_q.push_back(w);
    name_q.push_back(name);
  endtask

  task automatic sec_chk(input logic pr, input int st, input int c, input logic p,
                         input string name);
    step(1'b1, 1'b0, pr);
    expect_a(st, c, p, name);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sec_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset(input logic t1);
    @(negedge clk);
    rst_n     = 1'b0;
    tick_1s   = t1;
    tick_half = 1'b0;
    ped_req   = 1'b0;
    @(posedge clk);
    #1;
    expect_a(0, 10, 1'b0, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s act=%h exp=%h t=%0t", n, act, e, $time);
      end
    end
    while (exp2_q.size() > 0) begin
      logic [W-1:0] e;
      string n;
      e = exp2_q.pop_front();
      n = name2_q.pop_front();
      checks++;
      if (act2 !== e) begin
        errors++;
        $display("FAIL %s act=%h exp=%h t=%0t", n, act2, e, $time);
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    rst_n = 1'b0; tick_1s = 1'b0; tick_half = 1'b0; ped_req = 1'b0;

    // Reset state, both instances
    @(posedge clk); #1;
    expect_a(0, 10, 1'b0, "reset_default");
    exp2_q.push_back(ex(0, 25, 1'b0)); name2_q.push_back("reset_gm25");
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Full six-phase cycle
    m_st = 0; m_c = 10;
    for (int i = 1; i <= 23; i++) begin
      if (m_c == 1) begin
        m_st = (m_st + 1) % 6;
        m_c  = durs[m_st];
      end else begin
        m_c = m_c - 1;
      end
      step(1'b1, 1'b0, 1'b0);
      expect_a(m_st, m_c, 1'b0, "cycle");
      if (i == 6) begin
        exp2_q.push_back(ex(0, 19, 1'b0)); name2_q.push_back("gm25_after6");
      end
      step(1'b0, 1'b0, 1'b0);
    end

    // Pedestrian request at cnt=8
    sec_chk(1'b0, 0, 9, 1'b0, "pre_ped9");
    sec_chk(1'b0, 0, 8, 1'b0, "pre_ped8");
    step(1'b0, 1'b0, 1'b1);
    expect_a(0, 8, 1'b1, "ped_set");
    step(1'b0, 1'b0, 1'b0);
    expect_a(0, 3, 1'b1, "ped_clamp");
    sec_chk(1'b0, 0, 2, 1'b1, "ped_g2");
    sec_chk(1'b0, 0, 1, 1'b1, "ped_g1");
    sec_chk(1'b0, 1, 3, 1'b1, "ped_main_y");
    sec_chk(1'b0, 1, 2, 1'b1, "ped_y2");
    sec_chk(1'b0, 1, 1, 1'b1, "ped_y1");
    sec_chk(1'b0, 2, 1, 1'b1, "ped_red1");
    sec_chk(1'b0, 3, 5, 1'b0, "ped_clear_side_g");

    // Request coinciding with a second edge at cnt=5
    sec_quiet(9);
    expect_a(0, 10, 1'b0, "back_main_g");
    sec_quiet(5);
    sec_chk(1'b1, 0, 4, 1'b1, "ped_same_edge");
    step(1'b0, 1'b0, 1'b0);
    expect_a(0, 3, 1'b1, "ped_same_clamp");

    // Request on the cnt==1 edge: phase change wins
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    sec_quiet(9);
    sec_chk(1'b1, 1, 3, 1'b1, "ped_at_one");
    step(1'b0, 1'b0, 1'b0);
    expect_a(1, 3, 1'b1, "ped_hold_y");

    // Tick held high across reset release, then async reset in SIDE_G
    do_reset(1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_a(0, 10, 1'b0, "held_no_edge");
    step(1'b0, 1'b0, 1'b0);
    sec_chk(1'b0, 0, 9, 1'b0, "first_real_edge");
    sec_quiet(15);
    sec_chk(1'b0, 3, 2, 1'b0, "side_g_2");
    #2 rst_n = 1'b0;
    #1 expect_a(0, 10, 1'b0, "async_reset");
    @(negedge clk); rst_n = 1'b1;

    // Yellow lamp behaviour versus tick_half
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    sec_quiet(10);
    expect_a(1, 3, 1'b0, "yellow_entry");
    step(1'b0, 1'b1, 1'b0);
    w = ex(1, 3, 1'b0);
`ifdef YELLOW_BLINK_EN
    w[13] = 1'b0;
`endif
    expect_w(w, "yellow_half1");
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_a(1, 3, 1'b0, "yellow_half2");

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size() + exp2_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
